// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO read-mode constants and threshold helper
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // ge=1 tests value >= thresh (almost_full), ge=0 tests value <= thresh (almost_empty)
  function automatic logic thresh_check(input int value, input int thresh, input logic ge);
    return ge ? (value >= thresh) : (value <= thresh);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - pointer increment that wraps DEPTH-1 to 0 for any DEPTH
module fifo_ptr_wrap #(
  parameter int DEPTH = 16,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic [ADDR-1:0] ptr,
  output logic [ADDR-1:0] ptr_nxt
);

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

  assign ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;

endmodule

// File: rtl/fifo_ff_sync_prm.sv
// rtl/fifo_ff_sync_prm.sv - parameterised flip-flop synchronous FIFO, FWFT or registered read
module fifo_ff_sync_prm
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int ADDR     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    occup,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_bad_param
    $error("fifo_ff_sync_prm: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  localparam logic [ADDR:0] OCC_FULL = (ADDR + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             wr_acc, rd_acc;
  logic [ADDR:0]    occ_nxt;

  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign occ_nxt = occup + (ADDR + 1)'(wr_acc) - (ADDR + 1)'(rd_acc);

  fifo_ptr_wrap #(.DEPTH(DEPTH), .ADDR(ADDR)) u_wr_ptr (.ptr(wr_ptr), .ptr_nxt(wr_ptr_nxt));
  fifo_ptr_wrap #(.DEPTH(DEPTH), .ADDR(ADDR)) u_rd_ptr (.ptr(rd_ptr), .ptr_nxt(rd_ptr_nxt));

  // Status is registered from the next occupancy so it never depends on this cycle's inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occup        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_THRESH == 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      occup        <= occ_nxt;
      empty        <= (occ_nxt == '0);
      full         <= (occ_nxt == OCC_FULL);
      almost_empty <= thresh_check(int'(occ_nxt), AE_THRESH, 1'b0);
      almost_full  <= thresh_check(int'(occ_nxt), AF_THRESH, 1'b1);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_ff_sync_prm.sv
// tb/tb_fifo_ff_sync_prm.sv - randomized and directed check of both read modes against a queue model
module tb_fifo_ff_sync_prm;

  localparam int W = 8;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0] rd_data_f, rd_data_r;
  logic rd_valid_f, rd_valid_r;
  logic empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic empty_r, full_r, ae_r, af_r, ovf_r, unf_r;
  logic [3:0] occup_f, occup_r;

  always #5 clk = ~clk;

  fifo_ff_sync_prm #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f), .empty(empty_f), .full(full_f),
    .almost_empty(ae_f), .almost_full(af_f), .occup(occup_f),
    .overflow(ovf_f), .underflow(unf_f));

  fifo_ff_sync_prm #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_dut_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_r), .rd_valid(rd_valid_r), .empty(empty_r), .full(full_r),
    .almost_empty(ae_r), .almost_full(af_r), .occup(occup_r),
    .overflow(ovf_r), .underflow(unf_r));

  // Reference model: contents as a queue, plus the registered-read mode's output register.
  logic [W-1:0] q[$];
  bit m_ovf, m_unf, m_rv;
  logic [W-1:0] m_rd;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("occup", int'(occup_f), n);
    chk("empty", int'(empty_f), int'(n == 0));
    chk("full", int'(full_f), int'(n == D));
    chk("almost_full", int'(af_f), int'(n >= 4));
    chk("almost_empty", int'(ae_f), int'(n <= 1));
    chk("overflow", int'(ovf_f), int'(m_ovf));
    chk("underflow", int'(unf_f), int'(m_unf));
    chk("rd_valid_fwft", int'(rd_valid_f), int'(n != 0));
    if (n != 0) chk("rd_data_fwft", int'(rd_data_f), int'(q[0]));
    chk("occup_reg", int'(occup_r), n);
    chk("full_reg", int'(full_r), int'(n == D));
    chk("empty_reg", int'(empty_r), int'(n == 0));
    chk("rd_valid_reg", int'(rd_valid_r), int'(m_rv));
    chk("rd_data_reg", int'(rd_data_r), int'(m_rd));
  endtask

  task automatic step(input bit wr, input logic [W-1:0] d, input bit rd);
    int n;
    wr_en = wr; wr_data = d; rd_en = rd;
    n = q.size();
    m_ovf = wr && (n == D);
    m_unf = rd && (n == 0);
    m_rv  = rd && (n != 0);
    if (m_rv) m_rd = q.pop_front();
    if (wr && (n != D)) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_empty_lit", int'(empty_f), 1);
    chk("reset_ae_lit", int'(ae_f), 1);
    rst = 0;

    // fill, then one write too many
    for (int i = 1; i <= 6; i++) begin
      step(1, W'(8'h11 * i), 0);
      if (i == 4) chk("af_at_4_lit", int'(af_f), 1);
      if (i == 5) chk("full_after_5_lit", int'(full_f), 1);
    end
    chk("ovf_lit", int'(ovf_f), 1);
    chk("occup_5_lit", int'(occup_f), 5);
    chk("head_11_lit", int'(rd_data_f), 8'h11);

    for (int i = 1; i <= 6; i++) step(0, '0, 1);
    chk("unf_lit", int'(unf_f), 1);
    chk("empty_lit", int'(empty_f), 1);

    // pointer wrap
    for (int i = 0; i < 3; i++) step(1, W'(8'hC0 + i), 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, W'(8'hA0 + i), 0);
    chk("wrap_head_lit", int'(rd_data_f), 8'hA0);
    for (int i = 0; i < 5; i++) step(0, '0, 1);

    // simultaneous read/write at occup 2, full, and empty
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    for (int i = 0; i < 10; i++) step(1, W'(8'h30 + i), 1);
    chk("simul_occ2_lit", int'(occup_f), 2);
    for (int i = 0; i < 3; i++) step(1, W'(8'h50 + i), 0);
    step(1, 8'hEE, 1);
    chk("full_both_lit", int'(occup_f), 4);
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    step(1, 8'h66, 1);
    chk("empty_both_lit", int'(occup_f), 1);
    step(0, '0, 1);

    // registered read latency
    step(1, 8'h5A, 0);
    step(0, '0, 1);
    chk("reg_valid_lit", int'(rd_valid_r), 1);
    chk("reg_data_lit", int'(rd_data_r), 8'h5A);
    step(0, '0, 0);
    chk("reg_valid_drop_lit", int'(rd_valid_r), 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, W'(8'h90 + i), 0);
    #3 rst = 1;
    #1;
    model_reset();
    chk("async_occup_lit", int'(occup_f), 0);
    chk("async_empty_lit", int'(empty_f), 1);
    check_all();
    #1 rst = 0;
    step(1, 8'h77, 0);
    chk("post_reset_head_lit", int'(rd_data_f), 8'h77);
    step(0, '0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), W'($urandom), bit'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ff_sync_prm.md
FIFO_FF_SYNC_PRM -- requirements
Module: fifo_ff_sync_prm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (>=2; non-power-of-2 legal).
REQ-003 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read with 1-cycle latency.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2; almost_full asserts when occup >= AF_THRESH.
REQ-005 SHALL have parameter AE_THRESH, default 2; almost_empty asserts when occup <= AE_THRESH.
REQ-006 SHALL derive local ADDR = $clog2(DEPTH).
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_data  input  WIDTH  write data.
REQ-011 rd_en  input  1  read request (FWFT=1: pop/acknowledge head).
REQ-012 rd_data  output  WIDTH  read data.
REQ-013 rd_valid  output  1  rd_data valid qualifier.
REQ-014 empty / full  output  1 each  registered status.
REQ-015 almost_empty / almost_full  output  1 each  registered threshold status.
REQ-016 occup  output  ADDR+1  registered entry count, 0..DEPTH.
REQ-017 overflow / underflow  output  1 each  one-cycle error pulses.

Function
REQ-018 Write SHALL be accepted iff wr_en && !full; read accepted iff rd_en && !empty (flags as registered at that edge).
REQ-019 Simultaneous accepted read and write SHALL leave occup unchanged; full+both: read only; empty+both: write only.
REQ-020 wr_ptr/rd_ptr SHALL advance by 1 per accepted op and wrap from DEPTH-1 to 0 (no power-of-2 assumption).
REQ-021 occup, empty, full, almost_* SHALL update on the edge of the op, computed from next occup, no combinational path from inputs.
REQ-022 FWFT=1: rd_data SHALL be mem[rd_ptr] combinationally; rd_valid = !empty; a write to empty FIFO visible the cycle after the write edge.
REQ-023 FWFT=0: on accepted read rd_data SHALL register mem[rd_ptr] and rd_valid SHALL pulse 1 cycle; rd_data holds otherwise.
REQ-024 overflow SHALL pulse the cycle after wr_en && full; underflow the cycle after rd_en && empty; state unchanged by rejected ops.
REQ-025 Rejected write SHALL not modify memory; memory contents SHALL NOT be reset.
REQ-026 occup arithmetic SHALL be ADDR+1 bits, never exceed DEPTH nor go below 0.

Reset
REQ-027 On rst assertion (async), immediately: pointers=0, occup=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_THRESH=0), overflow=underflow=0, rd_valid=0, rd_data=0 in FWFT=0.
REQ-028 Reset mid-operation SHALL discard all entries; first op after deassertion behaves as on an empty FIFO.
REQ-029 Reset deassertion SHALL be synchronous to clk by the integrator; block adds no synchroniser.

Structure
REQ-030 Shared package fifo_pkg SHALL hold the FWFT mode constants (FIFO_MODE_FWFT, FIFO_MODE_REG) and a threshold-check function.
REQ-031 Pointer increment-with-wrap SHALL be a sub-module fifo_ptr_wrap (parameters DEPTH, ADDR), instanced twice.
REQ-032 Storage SHALL be flip-flop array; no RAM macros.
REQ-033 Elaboration SHALL fail if DEPTH<2, AF_THRESH>DEPTH or AE_THRESH>DEPTH.

Verification (WIDTH=8, DEPTH=5, AF=4, AE=1)
REQ-034 Reset, 5 writes 0x11..0x55 -> occup 1..5, almost_full at occup=4, full after 5th; 6th write -> overflow pulse, occup stays 5.
REQ-035 Full FIFO, 5 reads FWFT=1 -> rd_data 0x11..0x55 in order, empty after last; extra read -> underflow pulse.
REQ-036 Wrap: write 3, read 3, write 5 0xA0..0xA4 -> reads return 0xA0..0xA4, pointers wrap 4->0.
REQ-037 Simultaneous rd/wr at occup=2 for 10 cycles -> occup constant 2, data order preserved; at full -> read only; at empty -> write only.
REQ-038 FWFT=0: write 0x5A then rd_en -> rd_valid pulses and rd_data=0x5A one cycle after rd_en edge.
REQ-039 Assert rst asynchronously mid-stream at occup=3 -> flags/occup reset without clk edge; next write/read returns new data only.
